// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter: merges the core's instruction and data memory ports onto one
// shared req/gnt/recv/ack port. Requests are arbitrated round-robin with a lock
// that holds a stalled request stable until it is granted. Responses return in
// order, steered by a FIFO that records which side owns each outstanding
// transaction.

module frv_mem_arbiter #(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned XLEN        = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,

  input  logic            imem_req,
  input  logic            imem_wen,
  input  logic [3:0]      imem_strb,
  input  logic [XLEN-1:0] imem_wdata,
  input  logic [XLEN-1:0] imem_addr,
  output logic            imem_gnt,
  output logic            imem_recv,
  input  logic            imem_ack,
  output logic            imem_error,
  output logic [XLEN-1:0] imem_rdata,

  input  logic            dmem_req,
  input  logic            dmem_wen,
  input  logic [3:0]      dmem_strb,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_addr,
  output logic            dmem_gnt,
  output logic            dmem_recv,
  input  logic            dmem_ack,
  output logic            dmem_error,
  output logic [XLEN-1:0] dmem_rdata,

  output logic            bus_req,
  output logic            bus_wen,
  output logic [3:0]      bus_strb,
  output logic [XLEN-1:0] bus_wdata,
  output logic [XLEN-1:0] bus_addr,
  input  logic            bus_gnt,
  input  logic            bus_recv,
  output logic            bus_ack,
  input  logic            bus_error,
  input  logic [XLEN-1:0] bus_rdata,

  output logic            err_spurious
);

  localparam int unsigned CntW = $clog2(OUTSTANDING) + 1;
  // A one-entry FIFO still needs a one-bit pointer; it simply never leaves 0.
  localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  localparam logic [CntW-1:0] CntMax  = CntW'(OUTSTANDING);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(OUTSTANDING - 1);

  typedef enum logic {
    OwnImem = 1'b0,
    OwnDmem = 1'b1
  } owner_e;

  // Owner FIFO and arbitration state
  owner_e          fifo_q [OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            lock_q;
  owner_e          lock_owner_q;
  owner_e          last_winner_q;
  logic            err_spurious_q;

  // Combinational datapath signals
  owner_e          head;
  logic            busy;
  logic            head_ack;
  logic            pop;
  logic            issue_ok;
  owner_e          sel;
  logic            sel_req;
  logic            grant;

  // Response routing: forward the shared response to whichever side owns the FIFO head.
  always_comb begin
    head       = fifo_q[rd_ptr_q];
    busy       = (count_q != '0);
    head_ack   = (head == OwnDmem) ? dmem_ack : imem_ack;
    bus_ack    = !g_reset && busy && head_ack;
    imem_recv  = !g_reset && busy && bus_recv && (head == OwnImem);
    dmem_recv  = !g_reset && busy && bus_recv && (head == OwnDmem);
    imem_error = !g_reset && busy && bus_error && (head == OwnImem);
    dmem_error = !g_reset && busy && bus_error && (head == OwnDmem);
    imem_rdata = bus_rdata;
    dmem_rdata = bus_rdata;
    pop        = bus_recv && bus_ack;
  end

  // Request selection: a locked (stalled) request wins, otherwise round-robin.
  always_comb begin
    if (lock_q) begin
      sel = lock_owner_q;
    end else if (imem_req && dmem_req) begin
      sel = (last_winner_q == OwnImem) ? OwnDmem : OwnImem;
    end else if (dmem_req) begin
      sel = OwnDmem;
    end else begin
      sel = OwnImem;
    end
  end

  // Request muxing and grant steering; a full FIFO may still issue if it pops this cycle.
  always_comb begin
    issue_ok = (count_q < CntMax) || pop;
    if (sel == OwnDmem) begin
      sel_req   = dmem_req;
      bus_wen   = dmem_wen;
      bus_strb  = dmem_strb;
      bus_wdata = dmem_wdata;
      bus_addr  = dmem_addr;
    end else begin
      sel_req   = imem_req;
      bus_wen   = imem_wen;
      bus_strb  = imem_strb;
      bus_wdata = imem_wdata;
      bus_addr  = imem_addr;
    end
    bus_req  = !g_reset && sel_req && issue_ok;
    grant    = bus_req && bus_gnt;
    imem_gnt = grant && (sel == OwnImem);
    dmem_gnt = grant && (sel == OwnDmem);
  end

  assign err_spurious = err_spurious_q;

  // State update: FIFO push/pop, occupancy, lock, round-robin history, sticky error.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      for (int i = 0; i < int'(OUTSTANDING); i++) begin
        fifo_q[i] <= OwnImem;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      lock_q         <= 1'b0;
      lock_owner_q   <= OwnImem;
      last_winner_q  <= OwnImem;
      err_spurious_q <= 1'b0;
    end else begin
      if (grant) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        last_winner_q    <= sel;
        lock_q           <= 1'b0;
      end else if (bus_req) begin
        // Presented but not accepted: pin the selection until the grant arrives.
        lock_q       <= 1'b1;
        lock_owner_q <= sel;
      end

      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end

      unique case ({grant, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (bus_recv && !busy) begin
        err_spurious_q <= 1'b1;
      end
    end
  end

  // Occupancy must stay within the FIFO depth.
  a_count_bound: assert property (@(posedge g_clk) disable iff (g_reset) count_q <= CntMax);

  // A grant on a full FIFO is only legal when an entry leaves in the same cycle.
  a_no_overflow: assert property (@(posedge g_clk) disable iff (g_reset)
    !(grant && (count_q == CntMax) && !pop));

endmodule
